// File: rtl/grade_guess.sv
// Scores a guess against the stored master pattern: Znarly counts exact matches,
// Zood counts right-shape/wrong-position matches, over an 8-cycle sequential pass.
module grade_guess #(
    parameter int NUM_POS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3*NUM_POS-1:0] master_pattern,
    input  logic                 load_master,
    output logic                 master_loaded,
    input  logic [3*NUM_POS-1:0] guess,
    input  logic                 guess_valid,
    output logic                 guess_ready,
    output logic [3:0]           Znarly,
    output logic [3:0]           Zood,
    output logic                 result_valid,
    output logic                 guess_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic all_legal(input logic [3*NUM_POS-1:0] p);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_POS; i++) begin
            ok = ok & (p[3*i +: 3] != 3'd0) & (p[3*i +: 3] != 3'd7);
        end
        return ok;
    endfunction

    state_t               state_q, state_d;
    logic [3*NUM_POS-1:0] master_q, master_d;
    logic [3*NUM_POS-1:0] guess_q, guess_d;
    logic [NUM_POS-1:0]   used_q, used_d;
    logic                 master_loaded_q, master_loaded_d;
    logic [3:0]           znarly_acc_q, znarly_acc_d;
    logic [3:0]           zood_acc_q, zood_acc_d;
    logic [2:0]           shape_q, shape_d;
    logic [3:0]           znarly_q, znarly_d;
    logic [3:0]           zood_q, zood_d;
    logic                 result_valid_q, result_valid_d;
    logic                 guess_error_q, guess_error_d;

    logic                 idle_s, accept_s, load_ok_s;
    logic [3:0]           exact_cnt_s, cnt_g_s, cnt_m_s, min_s, zood_sum_s;
    logic [NUM_POS-1:0]   exact_mask_s;

    // Handshake and per-pass match counting over the registered patterns.
    always_comb begin
        idle_s       = (state_q == IDLE);
        guess_ready  = idle_s & master_loaded_q & ~load_master;
        accept_s     = guess_valid & guess_ready;
        load_ok_s    = idle_s & load_master & all_legal(master_pattern);
        exact_cnt_s  = 4'd0;
        exact_mask_s = '0;
        cnt_g_s      = 4'd0;
        cnt_m_s      = 4'd0;
        for (int i = 0; i < NUM_POS; i++) begin
            exact_mask_s[i] = (guess_q[3*i +: 3] == master_q[3*i +: 3]);
            exact_cnt_s     = exact_cnt_s + {3'd0, exact_mask_s[i]};
            // Positions consumed by an exact match are excluded from shape counts.
            cnt_g_s = cnt_g_s + {3'd0, (~used_q[i] & (guess_q[3*i +: 3] == shape_q))};
            cnt_m_s = cnt_m_s + {3'd0, (~used_q[i] & (master_q[3*i +: 3] == shape_q))};
        end
        if (cnt_g_s < cnt_m_s) begin
            min_s = cnt_g_s;
        end else begin
            min_s = cnt_m_s;
        end
        zood_sum_s = zood_acc_q + min_s;
    end

    // Next-state and next-output logic of the scoring FSM.
    always_comb begin
        state_d         = state_q;
        master_d        = master_q;
        guess_d         = guess_q;
        used_d          = used_q;
        master_loaded_d = master_loaded_q;
        znarly_acc_d    = znarly_acc_q;
        zood_acc_d      = zood_acc_q;
        shape_d         = shape_q;
        znarly_d        = znarly_q;
        zood_d          = zood_q;
        result_valid_d  = 1'b0;
        guess_error_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ok_s) begin
                    master_d        = master_pattern;
                    master_loaded_d = 1'b1;
                end else if (accept_s) begin
                    guess_d = guess;
                    if (all_legal(guess)) begin
                        state_d = EXACT;
                    end else begin
                        guess_error_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXACT: begin
                znarly_acc_d = exact_cnt_s;
                used_d       = exact_mask_s;
                zood_acc_d   = 4'd0;
                shape_d      = 3'd1;
                state_d      = COUNT;
            end
            COUNT: begin
                zood_acc_d = zood_sum_s;
                // Results are published on entry to DONE so they are fresh with result_valid.
                if (shape_q == 3'd6) begin
                    state_d        = DONE;
                    znarly_d       = znarly_acc_q;
                    zood_d         = zood_sum_s;
                    result_valid_d = 1'b1;
                end else begin
                    shape_d = shape_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            master_q        <= '0;
            guess_q         <= '0;
            used_q          <= '0;
            master_loaded_q <= 1'b0;
            znarly_acc_q    <= 4'd0;
            zood_acc_q      <= 4'd0;
            shape_q         <= 3'd1;
            znarly_q        <= 4'd0;
            zood_q          <= 4'd0;
            result_valid_q  <= 1'b0;
            guess_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            master_q        <= master_d;
            guess_q         <= guess_d;
            used_q          <= used_d;
            master_loaded_q <= master_loaded_d;
            znarly_acc_q    <= znarly_acc_d;
            zood_acc_q      <= zood_acc_d;
            shape_q         <= shape_d;
            znarly_q        <= znarly_d;
            zood_q          <= zood_d;
            result_valid_q  <= result_valid_d;
            guess_error_q   <= guess_error_d;
        end
    end

    assign master_loaded = master_loaded_q;
    assign Znarly        = znarly_q;
    assign Zood          = zood_q;
    assign result_valid  = result_valid_q;
    assign guess_error   = guess_error_q;

endmodule

// File: tb/tb_grade_guess.sv
// Scoreboard bench for grade_guess: stimulus pushes expected responses, a monitor pops on pulses.
module tb_grade_guess;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [3*N-1:0] master_pattern = '0;
    logic           load_master = 1'b0;
    logic           master_loaded;
    logic [3*N-1:0] guess = '0;
    logic           guess_valid = 1'b0;
    logic           guess_ready;
    logic [3:0]     Znarly, Zood;
    logic           result_valid, guess_error;

    grade_guess #(.NUM_POS(N)) dut (
        .clock(clock), .reset(reset),
        .master_pattern(master_pattern), .load_master(load_master),
        .master_loaded(master_loaded),
        .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
        .Znarly(Znarly), .Zood(Zood),
        .result_valid(result_valid), .guess_error(guess_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit err;
        int zn;
        int zo;
        int cyc;
    } exp_t;

    exp_t           q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             busy_until = 0;
    bit             m_loaded = 0;
    logic [3*N-1:0] m_pat = '0;
    int             last_zn = 0;
    int             last_zo = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [3*N-1:0] p);
        logic [2:0] s;
        for (int i = 0; i < N; i++) begin
            s = p[3*i +: 3];
            if (s == 3'd0 || s == 3'd7) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Mastermind identity: total common shapes minus exact hits gives the shape-only count.
    task automatic score(input logic [3*N-1:0] m, input logic [3*N-1:0] g,
                         output int zn, output int zo);
        int cm[8];
        int cg[8];
        int common;
        for (int s = 0; s < 8; s++) begin cm[s] = 0; cg[s] = 0; end
        zn = 0;
        for (int i = 0; i < N; i++) begin
            if (m[3*i +: 3] == g[3*i +: 3]) zn++;
            cm[m[3*i +: 3]]++;
            cg[g[3*i +: 3]]++;
        end
        common = 0;
        for (int s = 1; s <= 6; s++) common += (cm[s] < cg[s]) ? cm[s] : cg[s];
        zo = common - zn;
    endtask

    function automatic logic [3*N-1:0] pat(input int a, input int b, input int c, input int d);
        return {a[2:0], b[2:0], c[2:0], d[2:0]};
    endfunction

    function automatic logic [3*N-1:0] rpat(input bit allow_bad);
        logic [3*N-1:0] p;
        int v;
        for (int i = 0; i < N; i++) begin
            v = $urandom_range(1, 6);
            if (allow_bad && $urandom_range(0, 15) == 0) v = ($urandom_range(0, 1) == 0) ? 0 : 7;
            p[3*i +: 3] = v[2:0];
        end
        return p;
    endfunction

    task automatic step(input bit lm, input logic [3*N-1:0] mp,
                        input bit gv, input logic [3*N-1:0] g);
        int   zn, zo;
        bit   idle;
        exp_t e;
        @(negedge clock);
        load_master    = lm;
        master_pattern = mp;
        guess_valid    = gv;
        guess          = g;
        #1;
        idle = (cyc >= busy_until);
        check("guess_ready", guess_ready, (idle && m_loaded && !lm) ? 1 : 0);
        check("master_loaded", master_loaded, m_loaded);
        if (lm && idle) begin
            if (legal(mp)) begin
                m_pat    = mp;
                m_loaded = 1;
            end
        end else if (gv && idle && m_loaded && !lm) begin
            if (legal(g)) begin
                score(m_pat, g, zn, zo);
                e = '{0, zn, zo, cyc + 8};
                busy_until = cyc + 9;
            end else begin
                e = '{1, 0, 0, cyc + 1};
                busy_until = cyc + 1;
            end
            q.push_back(e);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0);
    endtask

    task automatic try_guess(input logic [3*N-1:0] g);
        step(0, '0, 1, g);
        idle_steps(9);
    endtask

    task automatic check_reset_values();
        check("rst_Znarly", Znarly, 0);
        check("rst_Zood", Zood, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_guess_error", guess_error, 0);
        check("rst_master_loaded", master_loaded, 0);
        check("rst_guess_ready", guess_ready, 0);
    endtask

    // Monitor: every pulse must match the oldest expected response, in cycle and value.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (result_valid || guess_error)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: result_valid=%0d guess_error=%0d with nothing pending (cycle %0d)",
                         result_valid, guess_error, cyc);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("result_valid", result_valid, e.err ? 0 : 1);
                check("guess_error", guess_error, e.err ? 1 : 0);
                if (!e.err) begin
                    check("Znarly", Znarly, e.zn);
                    check("Zood", Zood, e.zo);
                    last_zn = e.zn;
                    last_zo = e.zo;
                end else begin
                    check("Znarly_hold", Znarly, last_zn);
                    check("Zood_hold", Zood, last_zo);
                end
            end
        end
    end

    initial begin
        logic [3*N-1:0] g;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b0;

        repeat (3) step(0, '0, 1, pat(1, 2, 3, 4));
        step(1, pat(1, 2, 3, 4), 1, pat(1, 2, 3, 4));
        try_guess(pat(1, 2, 3, 4));
        try_guess(pat(4, 3, 2, 1));
        step(1, pat(1, 1, 2, 2), 0, '0);
        try_guess(pat(1, 2, 1, 3));
        try_guess(pat(2, 2, 1, 1));
        try_guess(pat(5, 5, 5, 5));
        try_guess(pat(0, 2, 3, 4));
        step(1, pat(7, 1, 1, 1), 0, '0);
        try_guess(pat(1, 1, 2, 3));
        repeat (20) step(0, '0, 1, pat(2, 1, 2, 1));
        idle_steps(9);

        step(0, '0, 1, pat(6, 1, 2, 2));
        idle_steps(3);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        q.delete();
        m_loaded   = 0;
        busy_until = 0;
        last_zn    = 0;
        last_zo    = 0;
        @(negedge clock);
        reset = 1'b0;
        idle_steps(12);

        step(1, pat(3, 4, 5, 6), 0, '0);
        for (int i = 0; i < 500; i++) begin
            g = rpat(1);
            step($urandom_range(0, 19) == 0, rpat(1), $urandom_range(0, 2) != 0, g);
        end
        idle_steps(12);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
